// File: rtl/mtimer_if.sv
// ============================================================================
//  Module   : mtimer_if
//  Purpose  : Load/store port between the MW stage and the machine timer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mtimer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  mem_acc_mode;
    logic        hit;
    logic [31:0] rdata;

    modport master (
        output addr, wdata, rd_en, wr_en, mem_acc_mode,
        input  hit, rdata
    );

    modport slave (
        input  addr, wdata, rd_en, wr_en, mem_acc_mode,
        output hit, rdata
    );
endinterface

`default_nettype wire

// File: rtl/mtimer.sv
// ============================================================================
//  Module   : mtimer
//  Purpose  : Memory-mapped prescaled 64-bit machine timer with compare irq.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mtimer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          PRESC_W   = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    mtimer_if.slave   bus,
    output logic      timer_interrupt
);

    localparam logic [2:0] C_OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] C_OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] C_OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] C_OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] C_OFF_CTRL     = 3'd4;
    localparam logic [2:0] C_OFF_PRESC    = 3'd5;
    localparam logic [2:0] C_OFF_STATUS   = 3'd6;
    localparam logic [2:0] C_MODE_WORD    = 3'b010;

    logic [63:0]        r_mtime;
    logic [63:0]        r_cmp;
    logic [31:0]        r_shadow;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pcnt;
    logic               r_en;
    logic               r_ie;
    logic               r_pend;
    logic               r_lvl_d;

    logic [2:0] w_off;
    logic       w_wr;
    logic       w_rd;
    logic       w_tick;
    logic       w_cmp_hit;
    logic       w_irq_lvl;
    logic       w_clr;

    assign w_off     = bus.addr[4:2];
    assign bus.hit   = (bus.addr[31:5] == BASE_ADDR[31:5]);
    assign w_wr      = bus.wr_en & bus.hit & (bus.mem_acc_mode == C_MODE_WORD);
    assign w_rd      = bus.rd_en & bus.hit;
    assign w_tick    = r_en & (r_pcnt == '0);
    assign w_cmp_hit = (r_mtime >= r_cmp);
    assign w_irq_lvl = r_pend & r_ie;
    assign w_clr     = w_wr & (((w_off == C_OFF_STATUS) & bus.wdata[0]) |
                               (w_off == C_OFF_CMP_LO) | (w_off == C_OFF_CMP_HI));

    always_comb begin
        bus.rdata = 32'd0;
        if (w_rd) begin
            case (w_off)
                C_OFF_MTIME_LO: bus.rdata = r_mtime[31:0];
                C_OFF_MTIME_HI: bus.rdata = r_shadow;
                C_OFF_CMP_LO:   bus.rdata = r_cmp[31:0];
                C_OFF_CMP_HI:   bus.rdata = r_cmp[63:32];
                C_OFF_CTRL:     bus.rdata = {30'd0, r_ie, r_en};
                C_OFF_PRESC:    bus.rdata = {{(32-PRESC_W){1'b0}}, r_presc};
                C_OFF_STATUS:   bus.rdata = {31'd0, r_pend};
                default:        bus.rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime  <= 64'd0;
            r_cmp    <= {64{1'b1}};
            r_shadow <= 32'd0;
            r_presc  <= '0;
            r_pcnt   <= '0;
            r_en     <= 1'b0;
            r_ie     <= 1'b0;
        end else begin
            // Prescaler: a PRESC write reloads the down-counter immediately
            if (w_wr && (w_off == C_OFF_PRESC)) begin
                r_pcnt <= bus.wdata[PRESC_W-1:0];
            end else if (r_en) begin
                r_pcnt <= (r_pcnt == '0) ? r_presc : r_pcnt - PRESC_W'(1);
            end

            // A software write to either mtime half wins over the tick
            if (w_wr && (w_off == C_OFF_MTIME_LO)) begin
                r_mtime[31:0] <= bus.wdata;
            end else if (w_wr && (w_off == C_OFF_MTIME_HI)) begin
                r_mtime[63:32] <= bus.wdata;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_rd && (w_off == C_OFF_MTIME_LO)) begin
                r_shadow <= r_mtime[63:32];
            end

            if (w_wr) begin
                case (w_off)
                    C_OFF_CMP_LO: r_cmp[31:0]  <= bus.wdata;
                    C_OFF_CMP_HI: r_cmp[63:32] <= bus.wdata;
                    C_OFF_CTRL: begin
                        r_en <= bus.wdata[0];
                        r_ie <= bus.wdata[1];
                    end
                    C_OFF_PRESC:  r_presc <= bus.wdata[PRESC_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Pending is sticky; a compare hit in the same cycle beats any clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend          <= 1'b0;
            r_lvl_d         <= 1'b0;
            timer_interrupt <= 1'b0;
        end else begin
            if (w_cmp_hit) begin
                r_pend <= 1'b1;
            end else if (w_clr) begin
                r_pend <= 1'b0;
            end
            r_lvl_d         <= w_irq_lvl;
            timer_interrupt <= w_irq_lvl & ~r_lvl_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mtimer.sv
// ============================================================================
//  Module   : tb_mtimer
//  Purpose  : Scoreboard bench for mtimer against a cycle-level register model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mtimer;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic clk;
    logic rst;
    logic timer_interrupt;

    mtimer_if bus();

    mtimer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .timer_interrupt (timer_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk_bus;
        bit          hit;
        logic [31:0] rdata;
        bit          irq;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 0;
    int   n_irq_seen = 0;

    // Reference model state
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_shadow;
    logic [15:0] m_presc, m_pcnt;
    bit          m_en, m_ie, m_pend, m_lvl_d, m_irq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            exp_t e;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got no expectation, expected one at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("irq", {63'd0, timer_interrupt}, {63'd0, e.irq});
                if (timer_interrupt === 1'b1) n_irq_seen++;
                if (e.chk_bus) begin
                    chk("hit", {63'd0, bus.hit}, {63'd0, e.hit});
                    chk("rdata", {32'd0, bus.rdata}, {32'd0, e.rdata});
                end
            end
        end
    end

    task automatic model_reset();
        m_time = 64'd0;  m_cmp = {64{1'b1}}; m_shadow = 32'd0;
        m_presc = 16'd0; m_pcnt = 16'd0;
        m_en = 0; m_ie = 0; m_pend = 0; m_lvl_d = 0; m_irq = 0;
    endtask

    // Drive one cycle, predict its outputs, then advance the model one clock
    task automatic step(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] mode);
        exp_t        e;
        bit          in_win, wok, tick, cmp_hit, lvl, clr;
        int          off;
        logic [31:0] val;
        logic [63:0] n_time;
        logic [15:0] n_pcnt;
        rst = r; bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.wdata = d;
        bus.mem_acc_mode = mode;

        in_win = (a >= BASE) && (a <= BASE + 32'd31);
        off    = int'((a - BASE) >> 2) & 7;
        case (off)
            0: val = m_time[31:0];
            1: val = m_shadow;
            2: val = m_cmp[31:0];
            3: val = m_cmp[63:32];
            4: val = {30'd0, m_ie, m_en};
            5: val = {16'd0, m_presc};
            6: val = {31'd0, m_pend};
            default: val = 32'd0;
        endcase
        e.chk_bus = rd || wr;
        e.hit     = in_win;
        e.rdata   = (rd && in_win) ? val : 32'd0;
        e.irq     = m_irq;
        q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            wok     = wr && in_win && (mode == 3'b010);
            tick    = m_en && (m_pcnt == 16'd0);
            cmp_hit = (m_time >= m_cmp);
            lvl     = m_pend && m_ie;
            clr     = wok && ((off == 6 && d[0]) || off == 2 || off == 3);

            if (wok && off == 5)  n_pcnt = d[15:0];
            else if (m_en)        n_pcnt = (m_pcnt == 0) ? m_presc : m_pcnt - 16'd1;
            else                  n_pcnt = m_pcnt;

            if (wok && off == 0)      n_time = {m_time[63:32], d};
            else if (wok && off == 1) n_time = {d, m_time[31:0]};
            else if (tick)            n_time = m_time + 64'd1;
            else                      n_time = m_time;

            if (rd && in_win && off == 0) m_shadow = m_time[63:32];
            if (wok && off == 2) m_cmp[31:0]  = d;
            if (wok && off == 3) m_cmp[63:32] = d;
            if (wok && off == 4) begin m_en = d[0]; m_ie = d[1]; end
            if (wok && off == 5) m_presc = d[15:0];

            m_pend  = cmp_hit ? 1'b1 : (clr ? 1'b0 : m_pend);
            m_irq   = lvl && !m_lvl_d;
            m_lvl_d = lvl;
            m_time  = n_time;
            m_pcnt  = n_pcnt;
        end
        @(posedge clk); #1;
    endtask

    task automatic wr32(input int off, input logic [31:0] d);
        step(0, 0, 1, BASE + 32'(off), d, 3'b010);
    endtask
    task automatic rd32(input int off);
        step(0, 1, 0, BASE + 32'(off), 32'd0, 3'b010);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, 32'd0, 3'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          off;
        logic [31:0] a, d;
        logic [2:0]  mode;
        rst = 1; bus.rd_en = 0; bus.wr_en = 0; bus.addr = 0; bus.wdata = 0;
        bus.mem_acc_mode = 3'b010;
        model_reset();
        @(posedge clk); #1;
        mon_on = 1;

        // Reset values of every offset
        step(1, 0, 0, 32'd0, 32'd0, 3'b010);
        step(1, 0, 0, 32'd0, 32'd0, 3'b010);
        for (int i = 0; i < 8; i++) rd32(i * 4);

        // Prescaled counting up to a compare hit, single pulse
        wr32(8'h14, 32'd3);
        wr32(8'h0C, 32'd0);
        wr32(8'h08, 32'd10);
        wr32(8'h10, 32'd3);
        for (int i = 0; i < 30; i++) begin rd32(8'h00); idle(1); end
        rd32(8'h18);

        // 32-bit carry and shadowed high read
        wr32(8'h10, 32'd0);
        wr32(8'h0C, 32'hFFFF_FFFF);
        wr32(8'h08, 32'hFFFF_FFFF);
        wr32(8'h18, 32'd1);
        wr32(8'h00, 32'hFFFF_FFFF);
        wr32(8'h04, 32'd0);
        wr32(8'h14, 32'd0);
        wr32(8'h10, 32'd1);
        rd32(8'h00);
        rd32(8'h00);
        wr32(8'h04, 32'd7);
        idle(3);
        rd32(8'h04);

        // Clear colliding with a live compare hit, then clear via CMP writes
        wr32(8'h10, 32'd2);
        wr32(8'h00, 32'd100);
        wr32(8'h04, 32'd0);
        wr32(8'h0C, 32'd0);
        wr32(8'h08, 32'd50);
        idle(3);
        wr32(8'h18, 32'd1);
        rd32(8'h18);
        wr32(8'h0C, 32'hFFFF_FFFF);
        wr32(8'h08, 32'hFFFF_FFFF);
        rd32(8'h18);
        wr32(8'h10, 32'd0);
        wr32(8'h10, 32'd2);
        rd32(8'h18);

        // Byte store ignored, out-of-window access
        step(0, 0, 1, BASE + 32'h10, 32'd1, 3'b000);
        rd32(8'h10);
        step(0, 1, 0, BASE + 32'h20, 32'd0, 3'b010);
        step(0, 1, 1, BASE + 32'h20, 32'd5, 3'b010);
        rd32(8'h10);

        // Reset right after a compare hit kills the pulse
        wr32(8'h18, 32'd1);
        wr32(8'h00, 32'd5);
        wr32(8'h0C, 32'd0);
        wr32(8'h08, 32'd5);
        idle(1);
        step(1, 0, 0, 32'd0, 32'd0, 3'b010);
        idle(3);
        for (int i = 0; i < 8; i++) rd32(i * 4);

        // Randomised register traffic
        for (int i = 0; i < 400; i++) begin
            off = $urandom_range(0, 7);
            a   = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            if ($urandom_range(0, 15) == 0) a = BASE + 32'h20 + 32'($urandom_range(0, 31));
            d    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
            if (off == 1 || off == 3) d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'd0;
            mode = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            case ($urandom_range(0, 3))
                0:       step(0, 1, 0, a, d, mode);
                1:       step(0, 0, 1, a, d, mode);
                2:       step(0, 1, 1, a, d, mode);
                default: step(0, 0, 0, a, d, mode);
            endcase
        end
        idle(2);

        mon_on = 0;
        n_cmp++;
        if (n_irq_seen == 0) begin
            n_bad++;
            $display("FAIL irq_seen: got 0 pulses, expected at least 1");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
